// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// the default operand width and a helper that sizes the bit counter.
package serial_sub_pkg;

    // Operand width used when the parent does not override N.
    localparam int SERIAL_SUB_DEFAULT_N = 8;

    // Controller states. The encodings are fixed so that waveforms and
    // any external decode of the state stay stable across revisions.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count from 0 up to n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_sub_full_sub_cell.sv
// One-bit full subtractor used by serial_sub: computes x - y - bin,
// giving the difference bit d and the borrow out bo.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    // Difference is the three-way parity; a borrow is needed when y
    // exceeds x, or when x equals y and a borrow is already pending.
    always_comb begin
        d  = x ^ y ^ bin;
        bo = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first,
// using a single full_sub_cell and a borrow flop. A start accepted at
// edge t produces a one-cycle done pulse in the cycle after edge t+N.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf; without it the port and its logic are absent.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int N = SERIAL_SUB_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = cnt_width(N);

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            last_bit;
    logic [N-1:0]    a_sh;
    logic [N-1:0]    b_sh;
    logic [N-1:0]    res;
    logic            br;
    logic [CW-1:0]   cnt;
    logic            cell_d;
    logic            cell_bo;

    // The operand shift registers present their current LSB to the cell;
    // the borrow flop closes the loop from one bit to the next.
    full_sub_cell u_cell (
        .x   (a_sh[0]),
        .y   (b_sh[0]),
        .bin (br),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    // Controller state register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the busy/done status, which are pure
    // functions of the current state. A start is only honoured from
    // IDLE or DONE, so a start during RUN leaves the operation alone.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        last_bit   = (cnt == CW'(N - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on an accepted start, then shift one
    // bit per RUN cycle, building the result from the MSB end so that
    // after N cycles bit 0 of the result sits at bit 0. The visible
    // outputs are loaded only on the final bit, i.e. on entry to DONE,
    // and otherwise hold their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= {cell_d, res[N-1:1]};
            br   <= cell_bo;
            if (last_bit) begin
                diff <= {cell_d, res[N-1:1]};
                bout <= cell_bo;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Signed overflow: on the final bit the cell sees the operand sign
    // bits and produces the result sign bit, so the overflow test can be
    // formed directly from the cell's inputs and difference output.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == RUN && last_bit && !accept) begin
            ovf <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ cell_d);
        end
    end
`endif

endmodule
